// File: rtl/dual_arb_pkg.sv
// Shared types for the dual-slot rotating-priority arbiter.
// Pick ids are sized for the largest legal requester count (16).
package dual_arb_pkg;

    localparam int N_REQ_DEF = 12;
    localparam int ID_W_DEF  = 4;

    typedef enum logic {SLOT_IDLE, SLOT_BUSY} slot_state_t;

    typedef struct packed {
        logic                valid;
        logic [ID_W_DEF-1:0] id;
    } pick_t;

endpackage

// File: rtl/dual_grant_arbiter_rr_pick2.sv
// Combinational dual pick: rotate so ptr lands on the top index, take the two
// highest set bits, then map the rotated positions back to requester indices.
module rr_pick2
    import dual_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic [N_REQ-1:0] elig,
    input  logic [ID_W-1:0]  ptr,
    output pick_t            first,
    output pick_t            second
);

    logic [N_REQ-1:0] rot;

    always_comb begin
        rot    = '0;
        first  = '0;
        second = '0;
        // Rotated position k holds requester (ptr + k + 1) mod N_REQ.
        for (int k = 0; k < N_REQ; k++) begin
            rot[k] = elig[ID_W'((int'(ptr) + k + 1) % N_REQ)];
        end
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                if (!first.valid) begin
                    first.valid = 1'b1;
                    first.id    = ID_W_DEF'((int'(ptr) + k + 1) % N_REQ);
                end else if (!second.valid) begin
                    second.valid = 1'b1;
                    second.id    = ID_W_DEF'((int'(ptr) + k + 1) % N_REQ);
                end
            end
        end
    end

endmodule

// File: rtl/dual_grant_arbiter.sv
// Two service slots shared among N_REQ requesters with rotating priority,
// per-slot hold timeout and a lockout mask for timed-out requesters.
module dual_grant_arbiter
    import dual_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int ID_W     = ID_W_DEF,
    parameter int MAX_HOLD = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt0_valid,
    output logic [ID_W-1:0]  gnt0_id,
    output logic             gnt1_valid,
    output logic [ID_W-1:0]  gnt1_id,
    output logic             timeout
);

    localparam bit                HOLD_EN   = (MAX_HOLD != 0);
    localparam int                CNT_W     = HOLD_EN ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);
    localparam logic [ID_W-1:0]   PTR_TOP   = ID_W'(N_REQ - 1);

    slot_state_t      state_q [2];
    slot_state_t      state_d [2];
    logic [ID_W-1:0]  id_q    [2];
    logic [ID_W-1:0]  id_d    [2];
    logic [CNT_W-1:0] cnt_q   [2];
    logic [CNT_W-1:0] cnt_d   [2];
    logic [N_REQ-1:0] lock_q, lock_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic             timeout_q, timeout_d;

    logic [N_REQ-1:0] held, elig;
    pick_t            first, second;
    logic             last_vld;
    logic [ID_W-1:0]  last_id;

    rr_pick2 #(.N_REQ(N_REQ), .ID_W(ID_W)) u_pick (
        .elig   (elig),
        .ptr    (ptr_q),
        .first  (first),
        .second (second)
    );

    always_comb begin
        held = '0;
        for (int s = 0; s < 2; s++) begin
            if (state_q[s] == SLOT_BUSY) held[id_q[s]] = 1'b1;
        end
        elig = req & ~held & ~lock_q;
    end

    always_comb begin
        lock_d    = lock_q & req;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        last_vld  = 1'b0;
        last_id   = '0;
        gnt_d     = '0;
        for (int s = 0; s < 2; s++) begin
            state_d[s] = state_q[s];
            id_d[s]    = id_q[s];
            cnt_d[s]   = cnt_q[s];
            if (state_q[s] == SLOT_BUSY) begin
                if (!req[id_q[s]]) begin
                    state_d[s] = SLOT_IDLE;
                    id_d[s]    = '0;
                end else if (HOLD_EN && cnt_q[s] == HOLD_LAST) begin
                    state_d[s]     = SLOT_IDLE;
                    id_d[s]        = '0;
                    timeout_d      = 1'b1;
                    lock_d[id_q[s]] = 1'b1;
                end else if (HOLD_EN) begin
                    cnt_d[s] = cnt_q[s] + 1'b1;
                end
            end
        end

        // Grants only go to slots idle before this edge, so a freed slot
        // always sees one idle cycle.
        if (state_q[0] == SLOT_IDLE && state_q[1] == SLOT_IDLE) begin
            if (first.valid) begin
                state_d[0] = SLOT_BUSY;
                id_d[0]    = first.id[ID_W-1:0];
                cnt_d[0]   = '0;
                last_vld   = 1'b1;
                last_id    = first.id[ID_W-1:0];
            end
            if (second.valid) begin
                state_d[1] = SLOT_BUSY;
                id_d[1]    = second.id[ID_W-1:0];
                cnt_d[1]   = '0;
                last_vld   = 1'b1;
                last_id    = second.id[ID_W-1:0];
            end
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (state_q[s] == SLOT_IDLE && first.valid) begin
                    state_d[s] = SLOT_BUSY;
                    id_d[s]    = first.id[ID_W-1:0];
                    cnt_d[s]   = '0;
                    last_vld   = 1'b1;
                    last_id    = first.id[ID_W-1:0];
                end
            end
        end

        if (last_vld) ptr_d = (last_id == '0) ? PTR_TOP : last_id - 1'b1;

        for (int s = 0; s < 2; s++) begin
            if (state_d[s] == SLOT_BUSY) gnt_d[id_d[s]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= SLOT_IDLE;
                id_q[s]    <= '0;
                cnt_q[s]   <= '0;
            end
            lock_q    <= '0;
            gnt_q     <= '0;
            ptr_q     <= PTR_TOP;
            timeout_q <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                state_q[s] <= state_d[s];
                id_q[s]    <= id_d[s];
                cnt_q[s]   <= cnt_d[s];
            end
            lock_q    <= lock_d;
            gnt_q     <= gnt_d;
            ptr_q     <= ptr_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt        = gnt_q;
    assign gnt0_valid = (state_q[0] == SLOT_BUSY);
    assign gnt0_id    = id_q[0];
    assign gnt1_valid = (state_q[1] == SLOT_BUSY);
    assign gnt1_id    = id_q[1];
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_dual_grant_arbiter.sv
// Directed bench for dual_grant_arbiter (N_REQ=12, MAX_HOLD=4).
module tb_dual_grant_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] req;
    logic [11:0] gnt;
    logic        gnt0_valid, gnt1_valid, timeout;
    logic [3:0]  gnt0_id, gnt1_id;

    int checks = 0;
    int errors = 0;

    dual_grant_arbiter #(.N_REQ(12), .ID_W(4), .MAX_HOLD(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .gnt        (gnt),
        .gnt0_valid (gnt0_valid),
        .gnt0_id    (gnt0_id),
        .gnt1_valid (gnt1_valid),
        .gnt1_id    (gnt1_id),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 12'hFFF;
        step();
        checks++;
        if (gnt !== 12'h000) begin
            errors++; $display("FAIL reset_gnt got %h want 000", gnt);
        end
        checks++;
        if ({gnt0_valid, gnt1_valid, timeout} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {gnt0_valid, gnt1_valid, timeout});
        end
        checks++;
        if ({gnt0_id, gnt1_id} !== 8'h00) begin
            errors++; $display("FAIL reset_ids got %h want 00", {gnt0_id, gnt1_id});
        end
        reset = 1'b0;
        req   = '0;
    endtask

    task automatic test_basic();
        do_reset();
        req = 12'hC00;
        step();
        checks++;
        if ({gnt0_valid, gnt0_id, gnt1_valid, gnt1_id} !== {1'b1, 4'd11, 1'b1, 4'd10}) begin
            errors++; $display("FAIL basic_pair got %b/%0d %b/%0d want 1/11 1/10", gnt0_valid, gnt0_id, gnt1_valid, gnt1_id);
        end
        checks++;
        if (gnt !== 12'hC00) begin
            errors++; $display("FAIL basic_gnt got %h want c00", gnt);
        end
        req = 12'h408;  // drop 11, raise 3
        step();
        checks++;
        if (gnt0_valid !== 1'b0 || gnt !== 12'h400) begin
            errors++; $display("FAIL release_gap got v0=%b gnt=%h want 0 400", gnt0_valid, gnt);
        end
        step();
        checks++;
        if (gnt0_valid !== 1'b1 || gnt0_id !== 4'd3 || gnt !== 12'h408) begin
            errors++; $display("FAIL regrant got v0=%b id0=%0d gnt=%h want 1 3 408", gnt0_valid, gnt0_id, gnt);
        end
    endtask

    task automatic test_fairness();
        logic [3:0] e0, e1;
        do_reset();
        req = 12'hFFF;
        for (int r = 0; r < 7; r++) begin
            e0 = 4'(11 - 2 * (r % 6));
            e1 = e0 - 4'd1;
            step();
            checks++;
            if ({gnt0_valid, gnt0_id, gnt1_valid, gnt1_id} !== {1'b1, e0, 1'b1, e1}) begin
                errors++; $display("FAIL fair_round%0d got %0d/%0d want %0d/%0d", r, gnt0_id, gnt1_id, e0, e1);
            end
            step();
            req[e0] = 1'b0;
            req[e1] = 1'b0;
            step();
            checks++;
            if ({gnt0_valid, gnt1_valid} !== 2'b00 || gnt !== 12'h000) begin
                errors++; $display("FAIL fair_idle%0d got v=%b gnt=%h want 00 000", r, {gnt0_valid, gnt1_valid}, gnt);
            end
            req = 12'hFFF;
        end
    endtask

    task automatic test_timeout();
        do_reset();
        req = 12'h003;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({gnt0_valid, gnt0_id, gnt1_valid, gnt1_id, timeout} !== {1'b1, 4'd1, 1'b1, 4'd0, 1'b0}) begin
                errors++; $display("FAIL to_busy%0d got %b/%0d %b/%0d to=%b want 1/1 1/0 0", i, gnt0_valid, gnt0_id, gnt1_valid, gnt1_id, timeout);
            end
        end
        step();
        checks++;
        if (timeout !== 1'b1 || gnt !== 12'h000 || {gnt0_valid, gnt1_valid} !== 2'b00) begin
            errors++; $display("FAIL to_pulse got to=%b gnt=%h want 1 000", timeout, gnt);
        end
        step();
        checks++;
        if (timeout !== 1'b0 || gnt !== 12'h000) begin
            errors++; $display("FAIL to_locked got to=%b gnt=%h want 0 000", timeout, gnt);
        end
        req = 12'h002;
        step();
        req = 12'h003;
        step();
        checks++;
        if ({gnt0_valid, gnt0_id, gnt1_valid} !== {1'b1, 4'd0, 1'b0} || gnt !== 12'h001) begin
            errors++; $display("FAIL to_unlock got %b/%0d v1=%b gnt=%h want 1/0 0 001", gnt0_valid, gnt0_id, gnt1_valid, gnt);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        req = 12'h006;
        step();
        checks++;
        if ({gnt0_id, gnt1_id} !== {4'd2, 4'd1}) begin
            errors++; $display("FAIL mid_setup got %0d/%0d want 2/1", gnt0_id, gnt1_id);
        end
        reset = 1'b1;
        step();
        checks++;
        if (gnt !== 12'h000 || {gnt0_valid, gnt1_valid, timeout} !== 3'b000) begin
            errors++; $display("FAIL mid_reset got gnt=%h flags=%b want 000 000", gnt, {gnt0_valid, gnt1_valid, timeout});
        end
        reset = 1'b0;
        req   = '0;
        step();
        req = 12'h003;
        step();
        checks++;
        if ({gnt0_valid, gnt0_id, gnt1_valid, gnt1_id} !== {1'b1, 4'd1, 1'b1, 4'd0}) begin
            errors++; $display("FAIL mid_ptr got %0d/%0d want 1/0", gnt0_id, gnt1_id);
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 12'h020;
        step();
        checks++;
        if ({gnt0_valid, gnt0_id, gnt1_valid, gnt1_id} !== {1'b1, 4'd5, 1'b0, 4'd0}) begin
            errors++; $display("FAIL single got %b/%0d %b/%0d want 1/5 0/0", gnt0_valid, gnt0_id, gnt1_valid, gnt1_id);
        end
        checks++;
        if (gnt !== 12'h020) begin
            errors++; $display("FAIL single_gnt got %h want 020", gnt);
        end
        step();
        checks++;
        if (gnt !== 12'h020 || gnt1_valid !== 1'b0) begin
            errors++; $display("FAIL single_hold got %h v1=%b want 020 0", gnt, gnt1_valid);
        end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        test_reset();
        test_basic();
        test_fairness();
        test_timeout();
        test_mid_reset();
        test_single();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
